// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce_bank family.
// Default timing constants are chosen for a 27 MHz board clock:
//   NDELAY        ~24 ms of stable input before the clean level follows
//   REPEAT_DELAY  ~300 ms hold before the first auto-repeat pulse
//   REPEAT_PERIOD ~100 ms between subsequent auto-repeat pulses
package debounce_pkg;

  localparam int DEF_NDELAY        = 650000;
  localparam int DEF_REPEAT_DELAY  = 8100000;
  localparam int DEF_REPEAT_PERIOD = 2700000;

  // Bits needed to hold values 0..n; never less than one bit.
  function automatic int cnt_width(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchroniser, saturating stability
// counter, clean level with registered press/release pulses and, when
// DEBOUNCE_REPEAT_EN is defined, a held-key auto-repeat pulse generator.
// The release pulse port is called release_o because "release" is a
// reserved word in SystemVerilog.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   NDELAY    = DEF_NDELAY,
  parameter logic RESET_VAL = 1'b0
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int   REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int   REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic press,
  output logic release_o,
  output logic rpt
);

  localparam int              CNT_W   = cnt_width(NDELAY);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NDELAY);

  logic             s1_q;
  logic             s2_q;
  logic             xnew_q;
  logic             xnew_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             clean_q;
  logic             clean_d;
  logic             press_q;
  logic             press_d;
  logic             rel_q;
  logic             rel_d;

  // Two-flop synchroniser for the asynchronous input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= noisy;
      s2_q <= s1_q;
    end
  end

  // Stability filter: any change restarts the count; once the count has
  // saturated the candidate level is (re)written into clean every cycle.
  always_comb begin
    xnew_d  = xnew_q;
    count_d = count_q;
    clean_d = clean_q;
    if (s2_q != xnew_q) begin
      xnew_d  = s2_q;
      count_d = '0;
    end else if (count_q == CNT_MAX) begin
      clean_d = xnew_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
    press_d = clean_d & ~clean_q;
    rel_d   = ~clean_d & clean_q;
  end

  // Filter state and registered edge pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xnew_q  <= RESET_VAL;
      count_q <= '0;
      clean_q <= RESET_VAL;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      xnew_q  <= xnew_d;
      count_q <= count_d;
      clean_q <= clean_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign clean     = clean_q;
  assign press     = press_q;
  assign release_o = rel_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int               RC_W      = cnt_width(REPEAT_DELAY);
  localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  RC_RELOAD = RC_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RC_W-1:0] rc_q;
  logic [RC_W-1:0] rc_d;
  logic            rpt_q;
  logic            rpt_d;

  // Hold timer: restarts on press, idles at zero while released. Reloading
  // to DELAY-PERIOD after each pulse makes later pulses PERIOD apart.
  // Looking at clean_d means a release suppresses a coinciding repeat.
  always_comb begin
    rc_d  = rc_q;
    rpt_d = 1'b0;
    if (!clean_d || press_d) begin
      rc_d = '0;
    end else if (rc_q == RC_LAST) begin
      rpt_d = 1'b1;
      rc_d  = RC_RELOAD;
    end else begin
      rc_d = rc_q + RC_W'(1);
    end
  end

  // Repeat timer and registered repeat pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rc_q  <= '0;
      rpt_q <= 1'b0;
    end else begin
      rc_q  <= rc_d;
      rpt_q <= rpt_d;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// NCHAN-wide pushbutton/switch debouncer built from independent
// debounce_chan instances. Optional held-key auto-repeat is built when
// the DEBOUNCE_REPEAT_EN macro is defined; otherwise rpt is all-zero.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int               NCHAN         = 4,
  parameter int               NDELAY        = DEF_NDELAY,
  parameter logic [NCHAN-1:0] RESET_VAL     = {NCHAN{1'b0}},
  parameter int               REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int               REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCHAN-1:0] noisy,
  output logic [NCHAN-1:0] clean,
  output logic [NCHAN-1:0] press,
  output logic [NCHAN-1:0] release_o,
  output logic [NCHAN-1:0] rpt
);

  // One fully independent filter per input.
  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    debounce_chan #(
      .NDELAY        (NDELAY),
      .RESET_VAL     (RESET_VAL[i])
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .noisy     (noisy[i]),
      .clean     (clean[i]),
      .press     (press[i]),
      .release_o (release_o[i]),
      .rpt       (rpt[i])
    );
  end

`ifndef DEBOUNCE_REPEAT_EN
  // Repeat parameters are accepted for a uniform interface but have no
  // effect in this build; this empty block only references them.
  if (REPEAT_PERIOD > REPEAT_DELAY) begin : g_repeat_params_unused
  end
`endif

endmodule
